// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (read-only) and
// the data stage (load/store), one transaction at a time.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   i_req/i_addr          fetch request, held until i_ready
//   i_rdata/i_ready       fetch data and one-cycle completion pulse
//   d_req/d_we/d_addr     data request, held with payload until d_ready
//   d_wdata/d_wmask       store data and byte enables
//   d_rdata/d_ready       load data and one-cycle completion pulse
//   mem_req/mem_we        registered transaction request / write enable
//   mem_addr/mem_wdata    registered address / write data
//   mem_wmask             registered byte mask, zero for reads
//   mem_rdata/mem_ready   memory read data and completion
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starveCnt;
    logic             starved;
    logic             grantD;
    logic             grantI;

    // Data wins unless fetch has already waited out STARVE_MAX data grants.
    assign starved = (starveCnt == CNT_W'(STARVE_MAX));
    assign grantD  = d_req && !(i_req && starved);
    assign grantI  = i_req && !grantD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grantD) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wmask <= d_we ? d_wmask : '0;
                        // A waiting fetch is only charged while it is pending.
                        starveCnt <= i_req ? starveCnt + CNT_W'(1) : '0;
                    end else if (grantI) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        starveCnt <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Ready is suppressed while reset is asserted so an abandoned access
    // never releases a stalled stage.
    assign i_ready = !reset && (state == BUSY_I) && mem_ready;
    assign d_ready = !reset && (state == BUSY_D) && mem_ready;
    assign i_rdata = i_ready ? mem_rdata : '0;
    assign d_rdata = d_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a
// variable-latency memory model and queue-driven requesters.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_rdata(i_rdata),
        .i_ready(i_ready),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_wmask(d_wmask),
        .d_rdata(d_rdata),
        .d_ready(d_ready),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } dreq_t;

    typedef struct {
        logic        isD;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        isD;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          lat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] iQ[$];
    dreq_t       dQ[$];
    exp_t        expQ[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rdFor(input logic [31:0] a,
                                          input logic we);
        if (we) return 32'h0;
        if (a == 32'h100) return 32'h00500093;
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory model: ready after memLat cycles of mem_req, or forced.
    int   memLat = 1;
    int   waitCnt = 0;
    logic readyAuto = 1'b0;
    logic forceEn = 1'b0;
    logic forceReady = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            readyAuto <= 1'b0;
            waitCnt   <= 0;
        end else if (readyAuto) begin
            readyAuto <= 1'b0;
        end else if (mem_req) begin
            if (waitCnt >= memLat - 1) begin
                readyAuto <= 1'b1;
                waitCnt   <= 0;
            end else begin
                waitCnt <= waitCnt + 1;
            end
        end else begin
            waitCnt <= 0;
        end
    end

    assign mem_ready = forceEn ? forceReady : readyAuto;
    assign mem_rdata = mem_ready ? rdFor(mem_addr, mem_we) : 32'h0;

    // Requesters: hold until ready, next request the cycle after.
    dreq_t dCur;

    always @(posedge clk) begin
        if (reset) begin
            i_req <= 1'b0;
        end else if (!i_req || i_ready) begin
            if (iQ.size() > 0) begin
                i_req  <= 1'b1;
                i_addr <= iQ.pop_front();
            end else begin
                i_req <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            d_req <= 1'b0;
        end else if (!d_req || d_ready) begin
            if (dQ.size() > 0) begin
                dCur = dQ.pop_front();
                d_req   <= 1'b1;
                d_we    <= dCur.we;
                d_addr  <= dCur.addr;
                d_wdata <= dCur.wdata;
                d_wmask <= dCur.mask;
            end else begin
                d_req <= 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    exp_t        monE;
    logic        prevReq = 1'b0;
    logic [36:0] prevCmd = '0;

    always @(negedge clk) begin
        check("both_ready", 64'(i_ready && d_ready), 64'(0));
        if (!i_ready) check("i_rdata_idle", 64'(i_rdata), 64'(0));
        if (!d_ready) check("d_rdata_idle", 64'(d_rdata), 64'(0));
        if (mem_req && prevReq)
            check("mem_hold", 64'({mem_we, mem_wmask, mem_addr}),
                  64'(prevCmd));
        if (i_ready || d_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready i=%0b d=%0b required none",
                         i_ready, d_ready);
            end else begin
                monE = expQ.pop_front();
                check("grant_side", 64'(d_ready), 64'(monE.isD));
                check("mem_addr", 64'(mem_addr), 64'(monE.addr));
                check("mem_we", 64'(mem_we), 64'(monE.we));
                check("mem_wmask", 64'(mem_wmask), 64'(monE.mask));
                if (monE.we)
                    check("mem_wdata", 64'(mem_wdata), 64'(monE.wdata));
                check("rdata", 64'(d_ready ? d_rdata : i_rdata),
                      64'(monE.rdata));
            end
        end
        prevReq <= mem_req;
        prevCmd <= {mem_we, mem_wmask, mem_addr};
    end

    task automatic pushData(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] m);
        dreq_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.mask = m;
        dQ.push_back(r);
    endtask

    task automatic expectTx(input logic isD, input logic we,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] m);
        exp_t e;
        e.isD = isD;
        e.addr = a;
        e.we = isD && we;
        e.wdata = wd;
        e.mask = (isD && we) ? m : 4'h0;
        e.rdata = rdFor(a, isD && we);
        expQ.push_back(e);
    endtask

    task automatic waitDone(input int budget, input string name);
        int n = 0;
        while ((expQ.size() != 0 || iQ.size() != 0 || dQ.size() != 0)
               && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done"}, 64'(expQ.size()), 64'(0));
        expQ.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_idle"}, 64'(mem_req), 64'(0));
    endtask

    // Queue nD data and nI fetch requests together; order is the
    // expected grant sequence.
    task automatic runOrder(input string order, input int nD,
                            input int nI, input string name);
        int dk = 0;
        int ik = 0;
        for (int k = 0; k < nD; k++)
            pushData(k[0], 32'h1000 + 32'(k * 4), 32'hC0DE0000 + 32'(k),
                     4'(k + 1));
        for (int k = 0; k < nI; k++)
            iQ.push_back(32'h200 + 32'(k * 4));
        for (int k = 0; k < order.len(); k++) begin
            if (order.getc(k) == 8'h44) begin
                expectTx(1'b1, dk[0], 32'h1000 + 32'(dk * 4),
                         32'hC0DE0000 + 32'(dk), 4'(dk + 1));
                dk++;
            end else begin
                expectTx(1'b0, 1'b0, 32'h200 + 32'(ik * 4), 32'h0, 4'h0);
                ik++;
            end
        end
        waitDone(300, name);
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 32'h00000100, 32'h0, 4'h0, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h00002004, 32'hDEADBEEF, 4'b0011, 1};
        vecs[2] = '{1'b1, 1'b0, 32'h00002008, 32'h12345678, 4'hF, 1};
        vecs[3] = '{1'b0, 1'b0, 32'h00000104, 32'h0, 4'h0, 1};
        vecs[4] = '{1'b1, 1'b1, 32'h0000300C, 32'hA5A55A5A, 4'b1000, 3};
        vecs[5] = '{1'b1, 1'b0, 32'h00000000, 32'h0, 4'h0, 4};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 2};
        vecs[7] = '{1'b1, 1'b1, 32'h80000000, 32'h00000001, 4'hF, 2};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_mem_wmask", 64'(mem_wmask), 64'(0));
        check("rst_ready", 64'({i_ready, d_ready}), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            memLat = vecs[v].lat;
            if (vecs[v].isD)
                pushData(vecs[v].we, vecs[v].addr, vecs[v].wdata,
                         vecs[v].wmask);
            else
                iQ.push_back(vecs[v].addr);
            expectTx(vecs[v].isD, vecs[v].we, vecs[v].addr,
                     vecs[v].wdata, vecs[v].wmask);
            waitDone(40, $sformatf("vec%0d", v));
        end

        memLat = 1;
        runOrder("DI", 1, 1, "simul_first");
        runOrder("DDD", 3, 0, "data_only");
        runOrder("DDDDID", 5, 1, "starve_clear");
        runOrder("DDDDIDDDDIDDI", 10, 3, "contention");
        memLat = 2;
        runOrder("DDDDIDI", 5, 2, "contention_lat2");

        // Back-to-back loads: exactly one idle cycle between them.
        memLat = 1;
        pushData(1'b0, 32'h400, 32'h0, 4'h0);
        pushData(1'b0, 32'h404, 32'h0, 4'h0);
        expectTx(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        expectTx(1'b1, 1'b0, 32'h404, 32'h0, 4'h0);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (d_ready) break;
            n++;
        end
        check("b2b_first", 64'(d_ready), 64'(1));
        @(negedge clk);
        check("b2b_gap", 64'(mem_req), 64'(0));
        @(negedge clk);
        check("b2b_next", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h404}));
        waitDone(20, "b2b");

        // Reset in BUSY_D with a ready arriving in the reset cycle.
        memLat = 20;
        pushData(1'b0, 32'h3000, 32'h0, 4'h0);
        n = 0;
        while (!mem_req && n < 10) begin
            @(posedge clk);
            n++;
        end
        check("rst_start", 64'(mem_req), 64'(1));
        @(posedge clk);
        #1;
        forceEn = 1'b1;
        forceReady = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy_noready", 64'(d_ready), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_memreq", 64'(mem_req), 64'(0));
        check("rst_idle_ready", 64'({i_ready, d_ready}), 64'(0));
        @(posedge clk);
        #1 forceEn = 1'b0;
        forceReady = 1'b0;
        @(negedge clk);
        check("rst_after_memreq", 64'(mem_req), 64'(0));

        memLat = 1;
        iQ.push_back(32'h100);
        expectTx(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        waitDone(20, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
